// File: rtl/led_frame_sequencer.sv
// Frame/blink sequencer for the 12-line LED pattern datapath; gates raw line levels into registered drive.
// Optional feature: define LED_SEQ_PAUSE_EN to add the pause_i freeze input.
module led_frame_sequencer #(
  parameter int unsigned CNT_W     = 9,
  parameter int unsigned FRAME_LEN = 500,
  parameter int unsigned LINES     = 12,
  parameter int unsigned BLINK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
`ifdef LED_SEQ_PAUSE_EN
  input  logic             pause_i,
`endif
  input  logic [7:0]       cfg_repeats,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [LINES-1:0] line_in,
  output logic [CNT_W-1:0] counter_o,
  output logic             toggle_o,
  output logic [LINES-1:0] line_out,
  output logic             busy_o,
  output logic             frame_start_o,
  output logic             done_o,
  output logic [7:0]       pass_o
);

  localparam int unsigned      DIV_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(FRAME_LEN);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] counter_d, gap_cnt, gap_cnt_d, gap_q, gap_q_d;
  logic [7:0]       rep_q, rep_q_d, pass_d, pass_inc;
  logic [DIV_W-1:0] div_q, div_d;
  logic             toggle_d, busy_d, fs_d, done_d;
  logic [LINES-1:0] line_d, line_gated;
  logic             pause;

`ifdef LED_SEQ_PAUSE_EN
  assign pause = pause_i;
`else
  assign pause = 1'b0;
`endif

  // Pass number wraps 255 -> 1 so a running sequence never reports pass 0.
  assign pass_inc   = (pass_o == 8'd255) ? 8'd1 : pass_o + 8'd1;
  assign line_gated = line_in & {LINES{toggle_o}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      counter_o     <= '0;
      toggle_o      <= 1'b0;
      line_out      <= '0;
      busy_o        <= 1'b0;
      frame_start_o <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= '0;
      rep_q         <= '0;
      gap_q         <= '0;
      gap_cnt       <= '0;
      div_q         <= '0;
    end else begin
      state         <= state_d;
      counter_o     <= counter_d;
      toggle_o      <= toggle_d;
      line_out      <= line_d;
      busy_o        <= busy_d;
      frame_start_o <= fs_d;
      done_o        <= done_d;
      pass_o        <= pass_d;
      rep_q         <= rep_q_d;
      gap_q         <= gap_q_d;
      gap_cnt       <= gap_cnt_d;
      div_q         <= div_d;
    end
  end

  // Next-state and next-output logic; line drive is only passed while staying in RUN.
  always_comb begin
    state_d   = state;
    counter_d = counter_o;
    toggle_d  = toggle_o;
    div_d     = div_q;
    gap_cnt_d = gap_cnt;
    rep_q_d   = rep_q;
    gap_q_d   = gap_q;
    pass_d    = pass_o;
    busy_d    = busy_o;
    fs_d      = 1'b0;
    done_d    = 1'b0;
    line_d    = '0;
    unique case (state)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d   = RUN;
          rep_q_d   = cfg_repeats;
          gap_q_d   = cfg_gap;
          counter_d = '0;
          pass_d    = 8'd1;
          toggle_d  = 1'b0;
          div_d     = '0;
          busy_d    = 1'b1;
          fs_d      = 1'b1;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d   = IDLE;
          counter_d = '0;
          busy_d    = 1'b0;
        end else if (!pause) begin
          if (div_q == DIV_LAST) begin
            div_d    = '0;
            toggle_d = ~toggle_o;
          end else begin
            div_d = div_q + 1'b1;
          end
          if (counter_o == LAST) begin
            counter_d = '0;
            if (rep_q != 8'd0 && pass_o == rep_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (gap_q == '0) begin
              pass_d = pass_inc;
              fs_d   = 1'b1;
              line_d = line_gated;
            end else begin
              state_d   = GAP;
              gap_cnt_d = CNT_W'(1);
            end
          end else begin
            counter_d = counter_o + 1'b1;
            line_d    = line_gated;
          end
        end
      end
      GAP: begin
        if (stop_i) begin
          state_d   = IDLE;
          counter_d = '0;
          busy_d    = 1'b0;
        end else if (!pause) begin
          if (gap_cnt == gap_q) begin
            state_d = RUN;
            pass_d  = pass_inc;
            fs_d    = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
